mem_bus_arbiter: RTL and testbench

//   Shared-memory arbiter between core0/core1 and the two slaves: RAM (512x8) and GPIO

---
 rtl/mem_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-core round-robin arbiter for a shared RAM/GPIO bus with bounded bursts.
// The owner's accesses are routed to one slave. Each access is acked one cycle after issue.
module mem_bus_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       reset,

    input  logic       core0_request,
    output logic       core0_grant,
    input  logic       core0_valid,
    input  logic       core0_rw,
    input  logic [9:0] core0_address,
    input  logic [7:0] core0_data_out,
    output logic [7:0] core0_data_in,
    output logic       core0_ack,

    input  logic       core1_request,
    output logic       core1_grant,
    input  logic       core1_valid,
    input  logic       core1_rw,
    input  logic [9:0] core1_address,
    input  logic [7:0] core1_data_out,
    output logic [7:0] core1_data_in,
    output logic       core1_ack,

    output logic       ram_en,
    output logic       ram_rw,
    output logic [8:0] ram_address,
    output logic [7:0] ram_data_in,
    input  logic [7:0] ram_data_out,

    output logic       gpio_en,
    output logic       gpio_rw,
    output logic [8:0] gpio_address,
    output logic [7:0] gpio_data_in,
    input  logic [7:0] gpio_data_out
);

    localparam int unsigned CW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_t;

    state_t          state, state_next;
    logic            last_owner;
    logic [CW-1:0]   burst_cnt;
    logic            pend_rd0, pend_rd1;
    logic            pend_gpio0, pend_gpio1;
    logic [7:0]      data_q0, data_q1;

    logic            issue0, issue1, issue;
    logic            acc_rw, acc_gpio;
    logic [9:0]      acc_address;
    logic [7:0]      acc_data;
    logic            burst_last;
    logic [7:0]      rd_data0, rd_data1;

    assign core0_grant = (state == StOwn0);
    assign core1_grant = (state == StOwn1);

    assign issue0 = core0_grant && core0_valid;
    assign issue1 = core1_grant && core1_valid;
    assign issue  = issue0 || issue1;

    assign acc_rw      = issue1 ? core1_rw       : core0_rw;
    assign acc_address = issue1 ? core1_address  : core0_address;
    assign acc_data    = issue1 ? core1_data_out : core0_data_out;
    assign acc_gpio    = acc_address[9];

    always_comb begin
        ram_en       = issue && !acc_gpio;
        gpio_en      = issue && acc_gpio;
        ram_rw       = ram_en && acc_rw;
        gpio_rw      = gpio_en && acc_rw;
        ram_address  = ram_en ? acc_address[8:0] : 9'd0;
        gpio_address = gpio_en ? acc_address[8:0] : 9'd0;
        ram_data_in  = ram_en ? acc_data : 8'd0;
        gpio_data_in = gpio_en ? acc_data : 8'd0;
    end

    assign burst_last = (MAX_BURST != 0) && (burst_cnt == CW'(MAX_BURST - 32'd1));

    always_comb begin
        state_next = state;
        unique case (state)
            StIdle: begin
                if (core0_request && core1_request) begin
                    state_next = last_owner ? StOwn0 : StOwn1;
                end else if (core0_request) begin
                    state_next = StOwn0;
                end else if (core1_request) begin
                    state_next = StOwn1;
                end
            end
            StOwn0: begin
                if (!core0_request) begin
                    state_next = core1_request ? StOwn1 : StIdle;
                end else if (core1_request && issue0 && burst_last) begin
                    state_next = StOwn1;
                end
            end
            StOwn1: begin
                if (!core1_request) begin
                    state_next = core0_request ? StOwn0 : StIdle;
                end else if (core0_request && issue1 && burst_last) begin
                    state_next = StOwn0;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    // Slave read data is only valid in the ack cycle, so it is bypassed to the core then
    // and captured for the following cycles.
    assign rd_data0      = pend_gpio0 ? gpio_data_out : ram_data_out;
    assign rd_data1      = pend_gpio1 ? gpio_data_out : ram_data_out;
    assign core0_data_in = (core0_ack && pend_rd0) ? rd_data0 : data_q0;
    assign core1_data_in = (core1_ack && pend_rd1) ? rd_data1 : data_q1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
            core0_ack  <= 1'b0;
            core1_ack  <= 1'b0;
            pend_rd0   <= 1'b0;
            pend_rd1   <= 1'b0;
            pend_gpio0 <= 1'b0;
            pend_gpio1 <= 1'b0;
            data_q0    <= 8'd0;
            data_q1    <= 8'd0;
        end else begin
            state <= state_next;
            if (state_next == StOwn0 && state != StOwn0) begin
                last_owner <= 1'b0;
            end else if (state_next == StOwn1 && state != StOwn1) begin
                last_owner <= 1'b1;
            end
            if (state_next != state) begin
                burst_cnt <= '0;
            end else if (issue) begin
                burst_cnt <= burst_cnt + CW'(1);
            end
            core0_ack  <= issue0;
            core1_ack  <= issue1;
            pend_rd0   <= issue0 && !core0_rw;
            pend_rd1   <= issue1 && !core1_rw;
            pend_gpio0 <= core0_address[9];
            pend_gpio1 <= core1_address[9];
            if (core0_ack && pend_rd0) begin
                data_q0 <= rd_data0;
            end
            if (core1_ack && pend_rd1) begin
                data_q1 <= rd_data1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a per-cycle vector table, then burst preemption
// and reset-during-access sequences.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic       r0, v0, rw0;
        logic [9:0] a0;
        logic [7:0] d0;
        logic       r1, v1, rw1;
        logic [9:0] a1;
        logic [7:0] d1;
        logic [7:0] rdo, gdo;
    } stim_t;

    typedef struct packed {
        logic       g0, g1, k0, k1;
        logic [7:0] di0, di1;
        logic       ren, rrw;
        logic [8:0] ra;
        logic [7:0] rdi;
        logic       gen, grw;
        logic [8:0] ga;
        logic [7:0] gdi;
    } resp_t;

    typedef struct packed {
        stim_t s;
        resp_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       core0_request = 0, core0_valid = 0, core0_rw = 0;
    logic [9:0] core0_address = '0;
    logic [7:0] core0_data_out = '0;
    logic       core1_request = 0, core1_valid = 0, core1_rw = 0;
    logic [9:0] core1_address = '0;
    logic [7:0] core1_data_out = '0;
    logic [7:0] ram_data_out = '0, gpio_data_out = '0;
    logic       core0_grant, core0_ack, core1_grant, core1_ack;
    logic [7:0] core0_data_in, core1_data_in;
    logic       ram_en, ram_rw, gpio_en, gpio_rw;
    logic [8:0] ram_address, gpio_address;
    logic [7:0] ram_data_in, gpio_data_in;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .core0_request(core0_request), .core0_grant(core0_grant),
        .core0_valid(core0_valid), .core0_rw(core0_rw), .core0_address(core0_address),
        .core0_data_out(core0_data_out), .core0_data_in(core0_data_in),
        .core0_ack(core0_ack),
        .core1_request(core1_request), .core1_grant(core1_grant),
        .core1_valid(core1_valid), .core1_rw(core1_rw), .core1_address(core1_address),
        .core1_data_out(core1_data_out), .core1_data_in(core1_data_in),
        .core1_ack(core1_ack),
        .ram_en(ram_en), .ram_rw(ram_rw), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .gpio_en(gpio_en), .gpio_rw(gpio_rw), .gpio_address(gpio_address),
        .gpio_data_in(gpio_data_in), .gpio_data_out(gpio_data_out)
    );

    always #5 clk = ~clk;

    resp_t act;
    assign act = '{core0_grant, core1_grant, core0_ack, core1_ack, core0_data_in,
                   core1_data_in, ram_en, ram_rw, ram_address, ram_data_in,
                   gpio_en, gpio_rw, gpio_address, gpio_data_in};

    function automatic stim_t st(logic r0, logic v0, logic rw0, logic [9:0] a0,
                                 logic [7:0] d0, logic r1, logic v1, logic rw1,
                                 logic [9:0] a1, logic [7:0] d1, logic [7:0] rdo,
                                 logic [7:0] gdo);
        return '{r0, v0, rw0, a0, d0, r1, v1, rw1, a1, d1, rdo, gdo};
    endfunction

    function automatic resp_t ex(logic g0, logic g1, logic k0, logic k1, logic [7:0] di0,
                                 logic [7:0] di1, logic ren, logic rrw, logic [8:0] ra,
                                 logic [7:0] rdi, logic gen, logic grw, logic [8:0] ga,
                                 logic [7:0] gdi);
        return '{g0, g1, k0, k1, di0, di1, ren, rrw, ra, rdi, gen, grw, ga, gdi};
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic apply(stim_t s);
        core0_request = s.r0; core0_valid = s.v0; core0_rw = s.rw0;
        core0_address = s.a0; core0_data_out = s.d0;
        core1_request = s.r1; core1_valid = s.v1; core1_rw = s.rw1;
        core1_address = s.a1; core1_data_out = s.d1;
        ram_data_out = s.rdo; gpio_data_out = s.gdo;
    endtask

    task automatic do_reset(string name);
        reset = 1'b0;
        apply('0);
        repeat (2) @(negedge clk);
        #1 chk(name, 64'(act), 64'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    vec_t tbl[$];

    initial begin
        int acks, extra, ovl;
        bit seen;

        // Inputs for cycle k are driven at the negedge; outputs sampled 1 ns later.
        tbl.push_back('{st(0,0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 8'hA5,8'h5A),
                        ex(0,0,0,0,8'h00,8'h00, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(1,1,0,10'h005,8'h00, 0,0,0,10'h000,8'h00, 8'hA5,8'h5A),
                        ex(0,0,0,0,8'h00,8'h00, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(1,1,0,10'h005,8'h00, 0,0,0,10'h000,8'h00, 8'hA5,8'h5A),
                        ex(1,0,0,0,8'h00,8'h00, 1,0,9'h005,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(1,0,0,10'h005,8'h00, 0,0,0,10'h000,8'h00, 8'hA5,8'h5A),
                        ex(1,0,1,0,8'hA5,8'h00, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(1,1,1,10'h203,8'h3C, 0,0,0,10'h000,8'h00, 8'hA5,8'h5A),
                        ex(1,0,0,0,8'hA5,8'h00, 0,0,9'h000,8'h00, 1,1,9'h003,8'h3C)});
        tbl.push_back('{st(1,0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 8'hA5,8'h77),
                        ex(1,0,1,0,8'hA5,8'h00, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(1,0,0,10'h000,8'h00, 0,1,0,10'h010,8'h00, 8'hA5,8'h77),
                        ex(1,0,0,0,8'hA5,8'h00, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(0,1,0,10'h100,8'h00, 1,0,0,10'h000,8'h00, 8'hA5,8'h77),
                        ex(1,0,0,0,8'hA5,8'h00, 1,0,9'h100,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(0,0,0,10'h000,8'h00, 1,1,0,10'h3FF,8'h00, 8'hC3,8'h77),
                        ex(0,1,1,0,8'hC3,8'h00, 0,0,9'h000,8'h00, 1,0,9'h1FF,8'h00)});
        tbl.push_back('{st(0,0,0,10'h000,8'h00, 1,0,0,10'h000,8'h00, 8'hC3,8'h66),
                        ex(0,1,0,1,8'hC3,8'h66, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(0,0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 8'h00,8'h00),
                        ex(0,1,0,0,8'hC3,8'h66, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(0,0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 8'h00,8'h00),
                        ex(0,0,0,0,8'hC3,8'h66, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(1,0,0,10'h000,8'h00, 1,0,0,10'h000,8'h00, 8'h00,8'h00),
                        ex(0,0,0,0,8'hC3,8'h66, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(1,0,0,10'h000,8'h00, 1,0,0,10'h000,8'h00, 8'h00,8'h00),
                        ex(1,0,0,0,8'hC3,8'h66, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(0,0,0,10'h000,8'h00, 1,0,0,10'h000,8'h00, 8'h00,8'h00),
                        ex(1,0,0,0,8'hC3,8'h66, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00)});
        tbl.push_back('{st(1,0,0,10'h000,8'h00, 1,0,0,10'h000,8'h00, 8'h00,8'h00),
                        ex(0,1,0,0,8'hC3,8'h66, 0,0,9'h000,8'h00, 0,0,9'h000,8'h00)});

        do_reset("reset_init");
        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i].s);
            #1 chk($sformatf("vec%0d", i), 64'(act), 64'(tbl[i].e));
        end

        // Burst preemption: core0 streams reads while core1 waits.
        do_reset("reset_burst");
        @(negedge clk);
        apply(st(1,1,0,10'h001,8'h00, 1,0,0,10'h000,8'h00, 8'h11,8'h22));
        acks = 0; ovl = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (core0_grant && core1_grant) ovl++;
            if (core0_ack) acks++;
            if (core1_grant) seen = 1;
        end
        chk("burst_handoff", 64'(seen), 64'd1);
        chk("burst_acks", 64'(acks), 64'd8);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (core0_ack) extra++;
            if (core0_grant && core1_grant) ovl++;
        end
        chk("burst_extra_ack", 64'(extra), 64'd0);
        chk("burst_owner1", 64'({core0_grant, core1_grant}), 64'b01);
        core1_request = 1'b0;
        seen = 0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (core0_grant && core1_grant) ovl++;
            if (core0_grant) seen = 1;
        end
        chk("burst_regrant0", 64'(seen), 64'd1);
        chk("burst_overlap", 64'(ovl), 64'd0);

        // Reset asserted the cycle after a read issue.
        do_reset("reset_mid_pre");
        @(negedge clk);
        core0_request = 1'b1;
        @(negedge clk);
        core0_valid = 1'b1; core0_rw = 1'b0; core0_address = 10'h005;
        ram_data_out = 8'hA5;
        @(posedge clk);
        #2 reset = 1'b0;
        core0_valid = 1'b0; core0_request = 1'b0;
        #1 chk("rst_mid_outputs", 64'(act), 64'd0);
        repeat (2) @(negedge clk);
        core0_request = 1'b1; core1_request = 1'b1;
        reset = 1'b1;
        #1 chk("rst_no_ack", 64'({core0_ack, core1_ack}), 64'd0);
        @(negedge clk);
        #1 chk("rst_tie", 64'({core0_grant, core1_grant, core0_ack, core0_data_in}),
               64'({1'b1, 1'b0, 1'b0, 8'h00}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
